// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed 7-segment display driver. A packed bus of 4-bit digit codes is
// captured into a display register on a load strobe. One digit is scanned
// at a time, and each digit stays enabled for SCAN_DIV clock cycles. The
// segment pattern, decimal point and digit enable are registered together,
// so all three pins change on the same edge.
//
// Parameters
//   NUM_DIGITS  number of scanned digits (1..8)
//   SCAN_DIV    clock cycles each digit stays enabled (>= 1)
//   HEX_MODE    1: codes 10..15 show A,b,C,d,E,F   0: codes 10..15 blank
//   ACTIVE_LOW  1: seg_out, dp_out and digit_en are inverted at the pins
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       capture strobe for digits_in / dp_in
//   digits_in  packed codes, digit 0 = bits [3:0] (rightmost)
//   dp_in      decimal point per digit
//   lz_blank   leading-zero blanking enable (live, not latched)
//   seg_out    segments ABCDEFG, A = bit 6, G = bit 0
//   dp_out     decimal point of the active digit
//   digit_en   one-hot active digit, bit i = digit i
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter bit HEX_MODE   = 1'b0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [PreW-1:0] LastPre = PreW'(SCAN_DIV - 1);

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dpReg_q, dpReg_d;
  logic [PreW-1:0]         prescale_q, prescale_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpOut_q, dpOut_d;
  logic [NUM_DIGITS-1:0]   digitEn_q, digitEn_d;

  logic [3:0] activeCode;
  logic       upperNonZero;
  logic       blankDigit;

  // Code to segment pattern (ABCDEFG, logical polarity).
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB: g = HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'hC: g = HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'hD: g = HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'hE: g = HEX_MODE ? 7'b1001111 : 7'b0000000;
      default: g = HEX_MODE ? 7'b1000111 : 7'b0000000;
    endcase
    return g;
  endfunction

  // Display register capture and scan timing. When the prescaler wraps on the
  // same edge as a load, both take effect together, so the next output shows
  // the new data on the new digit.
  always_comb begin
    digits_d   = load ? digits_in : digits_q;
    dpReg_d    = load ? dp_in : dpReg_q;
    prescale_d = prescale_q + PreW'(1);
    idx_d      = idx_q;
    if (prescale_q == LastPre) begin
      prescale_d = '0;
      idx_d      = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Leading-zero detection: the active digit is blanked when it and every
  // more significant digit hold code 0. Digit 0 always shows its glyph so a
  // value of zero still displays "0".
  always_comb begin
    activeCode   = digits_q[4*idx_q +: 4];
    upperNonZero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IdxW'(i) >= idx_q) && (digits_q[4*i +: 4] != 4'd0)) begin
        upperNonZero = 1'b1;
      end
    end
    blankDigit = lz_blank && (idx_q != '0) && !upperNonZero;
  end

  // Next output values, all derived from the pre-edge scan index.
  always_comb begin
    seg_d            = blankDigit ? 7'b0000000 : glyph(activeCode);
    dpOut_d          = dpReg_q[idx_q];
    digitEn_d        = '0;
    digitEn_d[idx_q] = 1'b1;
  end

  // All state, including the output register, clears asynchronously so a
  // reset mid-scan blanks the pins at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q   <= '0;
      dpReg_q    <= '0;
      prescale_q <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
      dpOut_q    <= 1'b0;
      digitEn_q  <= '0;
    end else begin
      digits_q   <= digits_d;
      dpReg_q    <= dpReg_d;
      prescale_q <= prescale_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dpOut_q    <= dpOut_d;
      digitEn_q  <= digitEn_d;
    end
  end

  // Pin polarity is applied after the register, so reset values invert too.
  assign seg_out  = seg_q ^ {7{ACTIVE_LOW}};
  assign dp_out   = dpOut_q ^ ACTIVE_LOW;
  assign digit_en = digitEn_q ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Three instances share the clock and input bus:
//   dutA  SCAN_DIV=4, HEX_MODE=0
//   dutB  SCAN_DIV=4, HEX_MODE=1
//   dutC  SCAN_DIV=1, ACTIVE_LOW=1, with its own reset
// Expected pin values are queued with the edge number they belong to when
// the stimulus is driven, and are popped and compared after that edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int ScanDiv = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rstC_n;
  logic        load;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn;
  logic        lzBlank;

  logic [6:0] segA, segB, segC;
  logic       dpA, dpB, dpC;
  logic [3:0] enA, enB, enC;

  typedef struct {
    int         cyc;
    int         sel;
    string      tag;
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sbQ[$];
  int   cycleNo = 0;
  int   relEdge = 0;
  int   totalChecks = 0;
  int   badChecks = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(ScanDiv), .HEX_MODE(1'b0), .ACTIVE_LOW(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digitsIn), .dp_in(dpIn),
    .lz_blank(lzBlank), .seg_out(segA), .dp_out(dpA), .digit_en(enA));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(ScanDiv), .HEX_MODE(1'b1), .ACTIVE_LOW(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digitsIn), .dp_in(dpIn),
    .lz_blank(lzBlank), .seg_out(segB), .dp_out(dpB), .digit_en(enB));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(1), .HEX_MODE(1'b0), .ACTIVE_LOW(1'b1)) dutC (
    .clk(clk), .rst_n(rstC_n), .load(load), .digits_in(digitsIn), .dp_in(dpIn),
    .lz_blank(lzBlank), .seg_out(segC), .dp_out(dpC), .digit_en(enC));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference glyph table, logical polarity.
  function automatic logic [6:0] refGlyph(input logic [3:0] c, input bit hex);
    logic [6:0] g;
    case (c)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    if (!hex && c >= 4'd10) g = 7'b0000000;
    return g;
  endfunction

  // Compare one expectation against the selected instance's pins.
  task automatic checkOutput(input exp_t e);
    logic [3:0] oe;
    logic [6:0] os;
    logic       od;
    case (e.sel)
      0:       begin oe = enA; os = segA; od = dpA; end
      1:       begin oe = enB; os = segB; od = dpB; end
      default: begin oe = enC; os = segC; od = dpC; end
    endcase
    totalChecks++;
    assert (oe === e.en) else begin
      badChecks++;
      $error("[TB] FAIL %s digit_en observed=%b expected=%b", e.tag, oe, e.en);
    end
    totalChecks++;
    assert (os === e.seg) else begin
      badChecks++;
      $error("[TB] FAIL %s seg_out observed=%b expected=%b", e.tag, os, e.seg);
    end
    totalChecks++;
    assert (od === e.dp) else begin
      badChecks++;
      $error("[TB] FAIL %s dp_out observed=%b expected=%b", e.tag, od, e.dp);
    end
  endtask

  task automatic checkNow(input int sel, input string tag, input logic [3:0] en,
                          input logic [6:0] seg, input logic dp);
    exp_t e;
    e.cyc = cycleNo; e.sel = sel; e.tag = tag; e.en = en; e.seg = seg; e.dp = dp;
    checkOutput(e);
  endtask

  task automatic expectAt(input int offs, input int sel, input string tag, input logic [3:0] en,
                          input logic [6:0] seg, input logic dp);
    exp_t e;
    e.cyc = cycleNo + offs; e.sel = sel; e.tag = tag; e.en = en; e.seg = seg; e.dp = dp;
    sbQ.push_back(e);
  endtask

  // Expected scan output for a SCAN_DIV=4 instance at the given future edge,
  // with d/dpv being the display register contents seen before that edge.
  task automatic expectScan(input int offs, input int sel, input string tag,
                            input logic [15:0] d, input logic [3:0] dpv, input bit lz);
    int         k;
    int         slot;
    bit         allZero;
    logic [3:0] code;
    logic [6:0] s;
    k       = relEdge + offs;
    slot    = ((k - 1) / ScanDiv) % 4;
    code    = d[4*slot +: 4];
    allZero = 1'b1;
    for (int j = slot; j < 4; j++) begin
      if (d[4*j +: 4] != 4'd0) allZero = 1'b0;
    end
    s = refGlyph(code, sel == 1);
    if (lz && slot != 0 && allZero) s = 7'b0000000;
    expectAt(offs, sel, tag, 4'(1 << slot), s, dpv[slot]);
  endtask

  // Advance one edge, then pop and compare everything due at this edge.
  task automatic tick();
    int i;
    @(posedge clk);
    if (rst_n) relEdge++;
    #1;
    cycleNo++;
    i = 0;
    while (i < sbQ.size()) begin
      if (sbQ[i].cyc <= cycleNo) begin
        checkOutput(sbQ[i]);
        sbQ.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Directed sequence.
  task automatic applyStimulus();
    // Reset state at the pins.
    rst_n = 1'b0; rstC_n = 1'b0; load = 1'b0; digitsIn = '0; dpIn = '0; lzBlank = 1'b0;
    #2;
    checkNow(0, "reset_a", 4'b0000, 7'b0000000, 1'b0);
    checkNow(2, "reset_c_inv", 4'b1111, 7'b1111111, 1'b1);
    runCycles(2);

    // Release and load 0210: four-cycle slots, digit 0 first.
    rst_n = 1'b1; load = 1'b1; digitsIn = 16'h0210;
    for (int k = 1; k <= 20; k++) expectScan(k, 0, "scan_0210", 16'h0210, 4'h0, 1'b0);
    tick();
    load = 1'b0;
    runCycles(19);

    // Leading-zero blanking of digit 3, then an all-zero value.
    lzBlank = 1'b1;
    for (int k = 1; k <= 16; k++) expectScan(k, 0, "lz_0210", 16'h0210, 4'h0, 1'b1);
    runCycles(16);
    load = 1'b1; digitsIn = 16'h0000;
    expectScan(1, 0, "lz_old", 16'h0210, 4'h0, 1'b1);
    for (int k = 2; k <= 16; k++) expectScan(k, 0, "lz_0000", 16'h0000, 4'h0, 1'b1);
    tick();
    load = 1'b0;
    runCycles(15);

    // Hex codes on both builds plus a decimal point on digit 2.
    lzBlank = 1'b0; load = 1'b1; digitsIn = 16'hFEDA; dpIn = 4'b0100;
    expectScan(1, 0, "hex_old_a", 16'h0000, 4'h0, 1'b0);
    expectScan(1, 1, "hex_old_b", 16'h0000, 4'h0, 1'b0);
    for (int k = 2; k <= 17; k++) begin
      expectScan(k, 0, "hex0_feda", 16'hFEDA, 4'b0100, 1'b0);
      expectScan(k, 1, "hex1_feda", 16'hFEDA, 4'b0100, 1'b0);
    end
    tick();
    load = 1'b0;
    runCycles(16);

    // Load in the middle of a slot: one edge of old glyph, then new.
    runCycles(2);
    load = 1'b1; digitsIn = 16'h8765; dpIn = 4'b0000;
    expectScan(1, 0, "midload_old", 16'hFEDA, 4'b0100, 1'b0);
    for (int k = 2; k <= 6; k++) expectScan(k, 0, "midload_new", 16'h8765, 4'h0, 1'b0);
    tick();
    load = 1'b0;
    runCycles(5);

    // Load on the same edge the scan index advances.
    while (((relEdge + 1) % ScanDiv) != 0) tick();
    load = 1'b1; digitsIn = 16'h4321; dpIn = 4'b0001;
    expectScan(1, 0, "swload_old", 16'h8765, 4'h0, 1'b0);
    for (int k = 2; k <= 5; k++) expectScan(k, 0, "swload_new", 16'h4321, 4'b0001, 1'b0);
    tick();
    load = 1'b0;
    runCycles(4);

    // Asynchronous reset between edges, mid-slot.
    tick();
    #3;
    rst_n = 1'b0;
    relEdge = 0;
    #1;
    checkNow(0, "async_rst_a", 4'b0000, 7'b0000000, 1'b0);
    checkNow(1, "async_rst_b", 4'b0000, 7'b0000000, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) expectScan(k, 0, "post_rst", 16'h0000, 4'h0, 1'b0);
    runCycles(8);

    // Active-low build scanning every cycle with code 1 on all digits.
    rstC_n = 1'b1; load = 1'b1; digitsIn = 16'h1111; dpIn = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      expectAt(k, 2, "actlow_scan", ~4'(1 << ((k - 1) % 4)),
               (k == 1) ? 7'b0000001 : 7'b1001111, 1'b1);
    end
    tick();
    load = 1'b0;
    runCycles(7);
  endtask

  initial begin
    applyStimulus();
    totalChecks++;
    assert (sbQ.size() == 0) else begin
      badChecks++;
      $error("[TB] FAIL sb_drain pending observed=%0d expected=0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
